// File: rtl/conv_host_seq.sv
// Host-side sequencer: streams kernel/matrix bytes into the convolution engine and collects its results.
// Optional macro RESULT_FIFO_EN selects a 4-entry result FIFO instead of a single output register.
module conv_host_seq #(
  parameter int MATRIX_DIM  = 16,
  parameter int CONV_DIM    = 3,
  parameter int NUM_RESULTS = (MATRIX_DIM - CONV_DIM + 1) * (MATRIX_DIM - CONV_DIM + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tpu_rst,
  output logic       tpu_insert_kernal,
  output logic       tpu_insert_matrix,
  output logic [7:0] tpu_data_in,
  output logic       tpu_ready,
  input  logic       tpu_done,
  input  logic [7:0] tpu_data_out,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
  output logic       busy,
  output logic       overflow
);

  localparam int K_TOTAL = CONV_DIM * CONV_DIM;
  localparam int M_TOTAL = MATRIX_DIM * MATRIX_DIM;
  localparam int K_W = $clog2(K_TOTAL + 1);
  localparam int M_W = $clog2(M_TOTAL + 1);
  localparam int R_W = $clog2(NUM_RESULTS + 1);
  localparam logic [K_W-1:0] K_LAST = K_W'(K_TOTAL - 1);
  localparam logic [M_W-1:0] M_LAST = M_W'(M_TOTAL - 1);
  localparam logic [R_W-1:0] R_LAST = R_W'(NUM_RESULTS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_LOAD_K, S_LOAD_M, S_RUN, S_DRAIN
  } state_t;

  state_t         state_q, state_d;
  logic [K_W-1:0] k_cnt_q, k_cnt_d;
  logic [M_W-1:0] m_cnt_q, m_cnt_d;
  logic [R_W-1:0] r_cnt_q, r_cnt_d;
  logic           overflow_q, overflow_d;

  // Result storage view shared by both storage variants
  logic       st_valid, st_last, st_free, can_capture;
  logic [7:0] st_data;
  logic       done_run, push, pop, push_last;

  assign done_run  = (state_q == S_RUN) && tpu_done;
  assign pop       = st_valid && out_ready;
  assign push      = done_run && can_capture;
  assign push_last = (r_cnt_q == R_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      k_cnt_q    <= '0;
      m_cnt_q    <= '0;
      r_cnt_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_cnt_q    <= k_cnt_d;
      m_cnt_q    <= m_cnt_d;
      r_cnt_q    <= r_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    k_cnt_d           = k_cnt_q;
    m_cnt_d           = m_cnt_q;
    r_cnt_d           = r_cnt_q;
    overflow_d        = overflow_q;
    in_ready          = 1'b0;
    tpu_rst           = 1'b0;
    tpu_insert_kernal = 1'b0;
    tpu_insert_matrix = 1'b0;
    tpu_data_in       = 8'd0;
    tpu_ready         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_SYNC;
          overflow_d = 1'b0;
        end
      end
      S_SYNC: begin
        tpu_rst = 1'b1;
        k_cnt_d = '0;
        m_cnt_d = '0;
        r_cnt_d = '0;
        state_d = S_LOAD_K;
      end
      S_LOAD_K: begin
        in_ready          = 1'b1;
        tpu_insert_kernal = in_valid;
        tpu_data_in       = in_data;
        if (in_valid) begin
          if (k_cnt_q == K_LAST) begin
            k_cnt_d = '0;
            state_d = S_LOAD_M;
          end else begin
            k_cnt_d = k_cnt_q + 1'b1;
          end
        end
      end
      S_LOAD_M: begin
        in_ready          = 1'b1;
        tpu_insert_matrix = in_valid;
        tpu_data_in       = in_data;
        if (in_valid) begin
          if (m_cnt_q == M_LAST) begin
            m_cnt_d = '0;
            state_d = S_RUN;
          end else begin
            m_cnt_d = m_cnt_q + 1'b1;
          end
        end
      end
      S_RUN: begin
        tpu_ready = st_free;
        if (done_run) begin
          r_cnt_d = r_cnt_q + 1'b1;
          if (!can_capture) overflow_d = 1'b1;
          // A dropped final result still ends the job; DRAIN then exits once storage empties
          if (push_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((pop && st_last) || !st_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef RESULT_FIFO_EN
  localparam int DEPTH = 4;
  logic [7:0]       fifo_data_q [DEPTH];
  logic [DEPTH-1:0] fifo_last_q;
  logic [1:0]       wr_ptr_q, rd_ptr_q;
  logic [2:0]       cnt_q;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst) begin
          fifo_data_q[gi] <= 8'd0;
          fifo_last_q[gi] <= 1'b0;
        end else if (push && (wr_ptr_q == 2'(gi))) begin
          fifo_data_q[gi] <= tpu_data_out;
          fifo_last_q[gi] <= push_last;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign st_valid    = (cnt_q != 3'd0);
  assign st_data     = fifo_data_q[rd_ptr_q];
  assign st_last     = fifo_last_q[rd_ptr_q];
  assign st_free     = (cnt_q != 3'(DEPTH));
  // Pop-first: a full FIFO still accepts a result in a cycle where the head leaves
  assign can_capture = st_free || pop;
`else
  logic [7:0] data_q;
  logic       valid_q, last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (push) begin
      data_q  <= tpu_data_out;
      valid_q <= 1'b1;
      last_q  <= push_last;
    end else if (pop) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

  assign st_valid    = valid_q;
  assign st_data     = data_q;
  assign st_last     = last_q;
  assign st_free     = !valid_q;
  assign can_capture = !valid_q || out_ready;
`endif

  assign out_valid = st_valid;
  assign out_data  = st_data;
  assign out_last  = st_valid && st_last;
  assign busy      = (state_q != S_IDLE);
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_conv_host_seq.sv
// Randomized self-checking bench for conv_host_seq against a byte/result-level reference model.
module tb_conv_host_seq;

  localparam int K_N   = 9;
  localparam int M_N   = 256;
  localparam int R_N   = 196;
`ifdef RESULT_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic       clk, rst, start;
  logic [7:0] in_data;
  logic       in_valid, in_ready;
  logic       tpu_rst, tpu_insert_kernal, tpu_insert_matrix;
  logic [7:0] tpu_data_in;
  logic       tpu_ready, tpu_done;
  logic [7:0] tpu_data_out, out_data;
  logic       out_valid, out_last, out_ready, busy, overflow;

  int tests_run = 0;
  int tests_failed = 0;

  conv_host_seq dut (
    .clk(clk), .rst(rst), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .tpu_rst(tpu_rst), .tpu_insert_kernal(tpu_insert_kernal),
    .tpu_insert_matrix(tpu_insert_matrix), .tpu_data_in(tpu_data_in),
    .tpu_ready(tpu_ready), .tpu_done(tpu_done), .tpu_data_out(tpu_data_out),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .busy(busy), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp_v);
    tests_run++;
    if (obs != exp_v) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_tpu_rst"}, tpu_rst, 0);
    check({tag, "_ins_k"}, tpu_insert_kernal, 0);
    check({tag, "_ins_m"}, tpu_insert_matrix, 0);
    check({tag, "_tpu_data_in"}, tpu_data_in, 0);
    check({tag, "_tpu_ready"}, tpu_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_overflow"}, overflow, 0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; tpu_done = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_quiet("reset");
  endtask

  // gap_mode: 0 back-to-back, 1 valid every other cycle, 2 random valid
  task automatic load_job(input int gap_mode, input bit fixed_data, input int stop_at);
    logic [7:0] bytes [K_N + M_N];
    int sent = 0;
    int cyc = 0;
    int nk = 0;
    int nm = 0;
    bit v;
    for (int i = 0; i < K_N + M_N; i++)
      bytes[i] = fixed_data ? ((i < K_N) ? 8'(i + 1) : 8'(i - K_N)) : 8'($urandom);
    @(negedge clk);
    start = 1'b1;
    #1;
    check("start_idle_busy", busy, 0);
    check("start_idle_tpu_rst", tpu_rst, 0);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("sync_tpu_rst", tpu_rst, 1);
    check("sync_busy", busy, 1);
    check("sync_in_ready", in_ready, 0);
    check("sync_no_insert", tpu_insert_kernal | tpu_insert_matrix, 0);
    while (sent < K_N + M_N && sent != stop_at && cyc < 4000) begin
      @(negedge clk);
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = cyc[0];
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v;
      in_data  = v ? bytes[sent] : 8'($urandom);
      #1;
      if (tpu_insert_kernal || tpu_insert_matrix || tpu_rst || !in_ready) begin
        check("load_in_ready", in_ready, 1);
        check("load_tpu_rst", tpu_rst, 0);
        check("load_ins_k", tpu_insert_kernal, int'(v && sent < K_N));
        check("load_ins_m", tpu_insert_matrix, int'(v && sent >= K_N));
      end else begin
        check("load_idle_cycle", int'(v), 0);
      end
      if (v) begin
        check("load_data", tpu_data_in, bytes[sent]);
        sent++;
      end
      nk += int'(tpu_insert_kernal);
      nm += int'(tpu_insert_matrix);
      cyc++;
    end
    if (cyc >= 4000) check("load_timeout", 0, 1);
    if (stop_at < 0) begin
      check("load_total_k", nk, K_N);
      check("load_total_m", nm, M_N);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("run_in_ready", in_ready, 0);
      check("run_tpu_ready", tpu_ready, 1);
      check("run_busy", busy, 1);
      check("run_no_insert", tpu_insert_kernal | tpu_insert_matrix, 0);
    end
  endtask

  // Engine model issues results only while permitted; all results must emerge in order
  task automatic run_results(input bit rand_ready);
    logic [7:0] exp_q [$];
    logic [7:0] d;
    int pushed = 0;
    int popped = 0;
    int cyc = 0;
    while (popped < R_N && cyc < 20000) begin
      @(negedge clk);
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      d = 8'($urandom);
      tpu_data_out = d;
      if (tpu_ready && pushed < R_N && $urandom_range(0, 3) != 0) begin
        tpu_done = 1'b1;
        exp_q.push_back(d);
        pushed++;
      end else begin
        tpu_done = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("res_spurious", 1, 0);
        end else begin
          popped++;
          check("res_data", out_data, exp_q.pop_front());
          check("res_last", out_last, int'(popped == R_N));
        end
      end
      cyc++;
    end
    if (cyc >= 20000) check("run_timeout", 0, 1);
    @(negedge clk);
    tpu_done = 1'b0;
    out_ready = 1'b0;
    #1;
    check("done_busy", busy, 0);
    check("done_out_valid", out_valid, 0);
    check("done_overflow", overflow, 0);
  endtask

  task automatic overflow_test();
    logic [7:0] exp_d [DEPTH + 1];
    out_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      @(negedge clk);
      check("ovf_tpu_ready", tpu_ready, int'(i < DEPTH));
      check("ovf_flag_early", overflow, 0);
      exp_d[i] = 8'($urandom);
      tpu_done = 1'b1;
      tpu_data_out = exp_d[i];
      #1;
    end
    @(negedge clk);
    tpu_done = 1'b0;
    #1;
    check("ovf_flag", overflow, 1);
    check("ovf_tpu_ready_full", tpu_ready, 0);
    check("ovf_held_valid", out_valid, 1);
    check("ovf_held_data", out_data, exp_d[0]);
    for (int j = 0; j < DEPTH; j++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      check("ovf_drain_valid", out_valid, 1);
      check("ovf_drain_data", out_data, exp_d[j]);
      check("ovf_drain_last", out_last, 0);
    end
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b1;
    #1;
    check("ovf_empty", out_valid, 0);
    check("ovf_sticky", overflow, 1);
    check("ovf_tpu_ready_again", tpu_ready, 1);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("ovf_start_ignored_rst", tpu_rst, 0);
    check("ovf_start_ignored_busy", busy, 1);
    check("ovf_start_ignored_flag", overflow, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_data = 8'd0; in_valid = 1'b0;
    tpu_done = 1'b0; tpu_data_out = 8'd0; out_ready = 1'b0;
    reset_dut();

    load_job(0, 1'b1, -1);
    run_results(1'b0);

    load_job(1, 1'b1, -1);
    run_results(1'b1);

    load_job(0, 1'b0, -1);
    overflow_test();
    reset_dut();

    load_job(2, 1'b0, K_N + 100);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hA5;
    #1;
    check("midload_insert_m", tpu_insert_matrix, 1);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check_quiet("abort");

    load_job(2, 1'b0, -1);
    run_results(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
